// File: rtl/fml_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fml_arbiter
// Purpose  : Shares one FML 4x32 SDRAM port among four masters. One whole
//            transaction is granted at a time (address phase plus burst),
//            and the port is then re-arbitrated round-robin.
// Option   : FMLARB_FIXED_PRIO_EN selects fixed priority (master 0 highest).
// Revision : 1.0 - initial release
// ============================================================================
module fml_arbiter #(
    parameter int sdram_depth = 26,
    parameter int burst_len   = 4
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [4*sdram_depth-1:0] m_adr,
    input  logic [3:0]               m_stb,
    input  logic [3:0]               m_we,
    input  logic [15:0]              m_sel,
    input  logic [127:0]             m_di,
    output logic [3:0]               m_ack,
    output logic [31:0]              m_do,
    output logic [sdram_depth-1:0]   s_adr,
    output logic                     s_stb,
    output logic                     s_we,
    output logic [3:0]               s_sel,
    output logic [31:0]              s_di,
    input  logic                     s_ack,
    input  logic [31:0]              s_do
);

    localparam int BW = (burst_len > 1) ? $clog2(burst_len) : 1;

    localparam logic [1:0]    c_idle      = 2'd0;
    localparam logic [1:0]    c_grant     = 2'd1;
    localparam logic [1:0]    c_burst     = 2'd2;
    localparam logic [BW-1:0] c_last_beat = BW'(burst_len - 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [BW-1:0] beat_q,  beat_d;
    logic [1:0]    w_winner;

`ifdef FMLARB_FIXED_PRIO_EN
    // Lowest index is visited last, so it wins.
    always_comb begin
        w_winner = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (m_stb[k]) w_winner = 2'(k);
        end
    end
`else
    logic [1:0] last_q, last_d;

    // Visit last+4 .. last+1 so that last+1 ends up with the highest priority.
    always_comb begin
        w_winner = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            if (m_stb[last_q + 2'(k)]) w_winner = last_q + 2'(k);
        end
    end
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= c_idle;
            grant_q <= 2'd0;
            beat_q  <= '0;
`ifndef FMLARB_FIXED_PRIO_EN
            last_q  <= 2'd3;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
`ifndef FMLARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        beat_d  = beat_q;
`ifndef FMLARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            c_idle: begin
                if (|m_stb) begin
                    grant_d = w_winner;
`ifndef FMLARB_FIXED_PRIO_EN
                    last_d  = w_winner;
`endif
                    state_d = c_grant;
                end
            end
            c_grant: begin
                // A master withdrawing before ack abandons its slot without issuing.
                if (!m_stb[grant_q]) begin
                    state_d = c_idle;
                end else if (s_ack) begin
                    beat_d  = '0;
                    state_d = c_burst;
                end
            end
            c_burst: begin
                beat_d = beat_q + BW'(1);
                if (beat_q == c_last_beat) state_d = c_idle;
            end
            default: state_d = c_idle;
        endcase
    end

    assign m_do = s_do;

    always_comb begin
        s_adr = m_adr[grant_q*sdram_depth +: sdram_depth];
        s_we  = m_we[grant_q];
        s_stb = 1'b0;
        m_ack = 4'h0;
        s_sel = 4'h0;
        s_di  = 32'h0;
        case (state_q)
            c_grant: begin
                s_stb          = m_stb[grant_q];
                m_ack[grant_q] = s_ack;
            end
            c_burst: begin
                s_sel = m_sel[grant_q*4 +: 4];
                s_di  = m_di[grant_q*32 +: 32];
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
